pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (legal range 1..256).
REQ-002 Parameter CLEAR_ON_FLUSH, default 1; 1 = out_data forced to 0 on flush, 0 = out_data holds its value on flush.
REQ-003 Parameter CNT_W, default 16, width of stall_cycles counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream payload valid.
REQ-007 in_ready  output  1  stage can accept; registered, no combinational path from out_ready.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  out_data valid.
REQ-010 out_ready  input  1  downstream accepts.
REQ-011 out_data  output  WIDTH  registered payload to downstream.
REQ-012 stall  input  1  hazard hold; while 1, downstream treated as not ready.
REQ-013 flush  input  1  kill all held entries (branch/exception).
REQ-014 occupancy  output  2  number of held entries, 0..2.
REQ-015 stall_cycles  output  CNT_W  saturating count of cycles with out_valid=1 and effective ready=0.

Function
REQ-016 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready & ~stall.
REQ-017 Storage: main register (drives out_data) plus one skid register, both WIDTH bits.
REQ-018 States: EMPTY (occupancy 0), BUSY (1), FULL (2); in_ready = 1 in EMPTY and BUSY, 0 in FULL; out_valid = 1 in BUSY and FULL.
REQ-019 EMPTY: in_fire -> BUSY, main <= in_data; otherwise stay.
REQ-020 BUSY, in_fire & out_fire -> BUSY, main <= in_data.
REQ-021 BUSY, in_fire & ~out_fire -> FULL, skid <= in_data, main unchanged.
REQ-022 BUSY, ~in_fire & out_fire -> EMPTY.
REQ-023 BUSY, neither -> hold.
REQ-024 FULL, out_fire -> BUSY, main <= skid; FULL, ~out_fire -> hold.
REQ-025 Latency: accepted payload appears on out_data the cycle after in_fire when main is free; order is strictly FIFO.
REQ-026 Payload never changes while out_valid=1 and out_fire=0.
REQ-027 flush has priority over all other events: next state EMPTY, same-cycle in_data discarded, same-cycle out_fire still counted as consumed by downstream.
REQ-028 CLEAR_ON_FLUSH=1: main and skid <= 0 on flush; CLEAR_ON_FLUSH=0: registers keep their contents, only the valid state clears.
REQ-029 stall & flush together: flush wins.
REQ-030 stall_cycles increments by 1 each cycle with out_valid=1 and (out_ready=0 or stall=1); it saturates at 2^CNT_W-1 and does not wrap; flush does not clear it.
REQ-031 Throughput: with out_ready=1 and stall=0 continuously, one transfer per cycle sustained.
REQ-032 occupancy is registered and equals the state encoding.

Reset
REQ-033 rst_n=0 asynchronously forces state EMPTY, out_valid=0, in_ready=1, out_data=0, skid=0, occupancy=0, stall_cycles=0.
REQ-034 In-flight payloads present at reset assertion are lost, and no out_valid pulse follows reset release.
REQ-035 First in_fire is accepted on the first rising edge after rst_n deasserts.

Verification
REQ-036 Stream: WIDTH=32, in_data 0x1,0x2,0x3 on consecutive cycles, out_ready=1 -> out_data 0x1,0x2,0x3 one cycle later each, occupancy stays 1, stall_cycles=0.
REQ-037 Backpressure: load 0xA, then 0xB with stall=1 -> occupancy=2, in_ready=0, out_data=0xA held; release stall -> 0xA then 0xB delivered in order, in_ready returns to 1 one cycle after the first out_fire.
REQ-038 Flush: FULL with 0xA/0xB, flush=1 with in_valid=1, in_data=0xC -> next cycle out_valid=0, occupancy=0, out_data=0 (CLEAR_ON_FLUSH=1), 0xC never appears.
REQ-039 Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cycles reaches 15 and holds at 15.
REQ-040 Reset mid-operation: FULL, assert rst_n=0 between clock edges -> outputs take reset values immediately; after release out_valid=0 until the next in_fire.
REQ-041 Simultaneous: BUSY holding 0x5, in_fire of 0x6 and out_fire in the same cycle -> BUSY, out_data=0x6 next cycle, occupancy=1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module      : pipe_stage_reg
// Description : Two-entry skid-buffered pipeline register with stall, flush
//               and a saturating downstream-backpressure cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
  parameter int WIDTH          = 32,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             stall,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [WIDTH-1:0] r_skid;

  logic w_in_fire;
  logic w_out_fire;
  logic w_blocked;
  logic w_cnt_max;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready & ~stall;
  assign w_blocked  = out_valid & (~out_ready | stall);
  assign w_cnt_max  = &stall_cycles;
  assign occupancy  = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_EMPTY;
      out_valid    <= 1'b0;
      in_ready     <= 1'b1;
      out_data     <= '0;
      r_skid       <= '0;
      stall_cycles <= '0;
    end else begin
      // Counter keeps running through flush; it only saturates.
      if (w_blocked && !w_cnt_max) begin
        stall_cycles <= stall_cycles + C_CNT_ONE;
      end

      if (flush) begin
        r_state   <= ST_EMPTY;
        out_valid <= 1'b0;
        in_ready  <= 1'b1;
        if (CLEAR_ON_FLUSH) begin
          out_data <= '0;
          r_skid   <= '0;
        end
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (w_in_fire) begin
              r_state   <= ST_BUSY;
              out_data  <= in_data;
              out_valid <= 1'b1;
            end
          end
          ST_BUSY: begin
            if (w_in_fire && w_out_fire) begin
              out_data <= in_data;
            end else if (w_in_fire) begin
              r_state  <= ST_FULL;
              r_skid   <= in_data;
              in_ready <= 1'b0;
            end else if (w_out_fire) begin
              r_state   <= ST_EMPTY;
              out_valid <= 1'b0;
            end
          end
          ST_FULL: begin
            if (w_out_fire) begin
              r_state  <= ST_BUSY;
              out_data <= r_skid;
              in_ready <= 1'b1;
            end
          end
          default: begin
            r_state   <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed self-checking bench for pipe_stage_reg.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_ready;
  logic             stall;
  logic             flush;

  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cycles;

  logic             h_in_ready;
  logic             h_out_valid;
  logic [WIDTH-1:0] h_out_data;
  logic [1:0]       h_occupancy;
  logic [CNT_W-1:0] h_stall_cycles;

  int n_cmp;
  int n_fail;

  pipe_stage_reg #(.WIDTH(WIDTH), .CLEAR_ON_FLUSH(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .stall(stall), .flush(flush),
    .occupancy(occupancy), .stall_cycles(stall_cycles)
  );

  pipe_stage_reg #(.WIDTH(WIDTH), .CLEAR_ON_FLUSH(1'b0), .CNT_W(CNT_W)) dut_hold (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(h_in_ready),
    .in_data(in_data), .out_valid(h_out_valid), .out_ready(out_ready),
    .out_data(h_out_data), .stall(stall), .flush(flush),
    .occupancy(h_occupancy), .stall_cycles(h_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_cmp++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    n_cmp++; if (stall_cycles !== 4'd0) begin n_fail++; $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    logic [WIDTH-1:0] vals [3];
    vals[0] = 32'h1; vals[1] = 32'h2; vals[2] = 32'h3;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = vals[i];
      step();
      n_cmp++; if (out_data !== vals[i] || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL stream_data[%0d]: got %h/%b want %h/1", i, out_data, out_valid, vals[i]);
      end
      n_cmp++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL stream_occ[%0d]: got %0d want 1", i, occupancy); end
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_fail++; $display("FAIL stream_drain: got valid %b occ %0d want 0/0", out_valid, occupancy);
    end
    n_cmp++; if (stall_cycles !== 4'd0) begin n_fail++; $display("FAIL stream_stall_cycles: got %0d want 0", stall_cycles); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    stall     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    step();
    in_data = 32'hB;
    stall   = 1'b1;
    step();
    n_cmp++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_full: got occ %0d in_ready %b want 2/0", occupancy, in_ready);
    end
    n_cmp++; if (out_data !== 32'hA) begin n_fail++; $display("FAIL bp_hold_a: got %h want a", out_data); end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_data !== 32'hA || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_still_a: got %h/%b want a/1", out_data, out_valid);
    end
    n_cmp++; if (stall_cycles !== 4'd2) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d want 2", stall_cycles); end
    stall = 1'b0;
    step();
    n_cmp++; if (out_data !== 32'hB || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: got %h occ %0d rdy %b want b/1/1", out_data, occupancy, in_ready);
    end
    step();
    n_cmp++; if (out_valid !== 1'b0 || stall_cycles !== 4'd2) begin
      n_fail++; $display("FAIL bp_drain: got valid %b cnt %0d want 0/2", out_valid, stall_cycles);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    step();
    in_data = 32'hB;
    step();
    n_cmp++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL flush_setup: got occ %0d want 2", occupancy); end
    flush   = 1'b1;
    in_data = 32'hC;
    step();
    n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 32'h0) begin
      n_fail++; $display("FAIL flush_clear: got valid %b occ %0d data %h want 0/0/0", out_valid, occupancy, out_data);
    end
    n_cmp++; if (h_out_valid !== 1'b0 || h_out_data !== 32'hA) begin
      n_fail++; $display("FAIL flush_hold_variant: got valid %b data %h want 0/a", h_out_valid, h_out_data);
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b0 || out_data === 32'hC) begin
        n_fail++; $display("FAIL flush_no_c[%0d]: got valid %b data %h want 0/not c", i, out_valid, out_data);
      end
    end
  endtask

  task automatic test_saturation();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h5A;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 5 || k == 15 || k == 20) begin
        n_cmp++; if (stall_cycles !== ((k > 15) ? 4'd15 : 4'(k))) begin
          n_fail++; $display("FAIL sat_count[%0d]: got %0d want %0d", k, stall_cycles, (k > 15) ? 15 : k);
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    idle_inputs();
    in_valid = 1'b1;
    in_data  = 32'h11;
    step();
    in_data = 32'h22;
    step();
    n_cmp++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL midrst_setup: got occ %0d want 2", occupancy); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || occupancy !== 2'd0 || stall_cycles !== 4'd0) begin
      n_fail++; $display("FAIL midrst_async: got v%b r%b d%h o%0d c%0d want 0/1/0/0/0", out_valid, in_ready, out_data, occupancy, stall_cycles);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #2 rst_n = 1'b1;
    step();
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_pulse: got %b want 0", out_valid); end
    in_valid = 1'b1;
    in_data  = 32'h7;
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h7) begin
      n_fail++; $display("FAIL midrst_first: got %b/%h want 1/7", out_valid, out_data);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    in_valid = 1'b1;
    in_data  = 32'h5;
    step();
    in_data   = 32'h6;
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_data !== 32'h6 || occupancy !== 2'd1 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b: got %h occ %0d v%b want 6/1/1", out_data, occupancy, out_valid);
    end
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    idle_inputs();
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_reset_midop();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
